// File: rtl/dmem_line_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_line_responder_pkg : shared widths, state type and sizing helpers   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package dmem_line_responder_pkg;

  localparam int DMEM_LINE_W = 256;
  localparam int LINE_OFF_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // LATENCY=1 still needs a one-bit counter that only ever holds zero.
  function automatic int cnt_w(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_line_responder_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_line_array : DEPTH x LINE_W storage, one write port, registered read|
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_line_array
  import dmem_line_responder_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int LINE_W = DMEM_LINE_W,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] rdata_d;

  // Storage is deliberately left out of reset; only the read register clears.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_line_responder : fixed-latency line memory target for dcache refill |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_line_responder
  import dmem_line_responder_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int LINE_W  = DMEM_LINE_W,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int CNT_W = cnt_w(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic               commit;
  logic               arr_we;
  logic               arr_re;
  logic               unused_addr;

  // Offset and high address bits alias onto the same line by design.
  assign unused_addr = ^addr_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[LINE_OFF_W +: IDX_W];
          wr_d    = write_i;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk_i) begin
    idx_q   <= idx_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  // Reset on the commit edge suppresses both the array write and the read load.
  assign arr_we = commit &  wr_q & ~rst_i;
  assign arr_re = commit & ~wr_q & ~rst_i;

  dmem_line_array #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

  assign ack_o = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_line_responder : self-checking bench for dmem_line_responder     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dmem_line_responder;

  localparam int LAT   = 10;
  localparam int DEPTH = 512;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;

  dmem_line_responder #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .LINE_W  (256),
    .ADDR_W  (32)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: line store plus the last-read value.
  logic [255:0] model_mem [DEPTH];
  logic [255:0] model_data;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp_data;
  } vec_t;

  vec_t table_v [5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] preload_val(input int i);
    logic [31:0] w;
    if (i == 3) return {32{8'hA5}};
    w = 32'hC0DE_0000 | 32'(i);
    return {8{w}};
  endfunction

  // One full transaction from acceptance to the return to idle.
  // fixed_scr forces a write to line 7 on the inputs right after acceptance.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [255:0] d,
                        input bit fixed_scr);
    int idx;
    idx = int'(addr[5 +: 9]);
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = d;
    @(posedge clk_i); #1;
    check("ack_at_accept", {255'd0, ack_o}, 256'd0);
    if (fixed_scr) begin
      write_i = 1'b1;
      addr_i  = 32'h0000_00E0;
      data_i  = '1;
    end else begin
      write_i = 1'($urandom);
      addr_i  = $urandom;
      data_i  = {8{$urandom}};
      if ($urandom_range(3) == 0) enable_i = 1'b0;
    end
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk_i); #1;
      check("ack_wait", {255'd0, ack_o}, 256'd0);
    end
    @(posedge clk_i); #1;
    if (wr) model_mem[idx] = d;
    else    model_data     = model_mem[idx];
    check("ack_pulse", {255'd0, ack_o}, 256'd1);
    check("data_o", data_o, model_data);
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    check("ack_clear", {255'd0, ack_o}, 256'd0);
  endtask

  initial begin
    bit           exp_ack;
    logic [255:0] pre5;

    rst_i    = 1'b1;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    model_data = '0;
    pre5 = preload_val(5);

    table_v[0] = '{wr: 1'b0, addr: 32'h0000_0060, data: '0,           exp_data: {32{8'hA5}}};
    table_v[1] = '{wr: 1'b1, addr: 32'h0000_0080, data: 256'h1234,   exp_data: {32{8'hA5}}};
    table_v[2] = '{wr: 1'b0, addr: 32'h0000_009C, data: '0,           exp_data: 256'h1234};
    table_v[3] = '{wr: 1'b1, addr: 32'h0000_4020, data: 256'hDEAD,   exp_data: 256'h1234};
    table_v[4] = '{wr: 1'b0, addr: 32'h0000_0020, data: '0,           exp_data: 256'hDEAD};

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ack", {255'd0, ack_o}, 256'd0);
    check("reset_data", data_o, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Fill every line through the write path so the model knows all contents.
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(1'b1, 32'(i) << 5, preload_val(i), 1'b0);
    end
    check("preload_data_o", data_o, 256'd0);

    for (int v = 0; v < 5; v++) begin
      do_txn(table_v[v].wr, table_v[v].addr, table_v[v].data, 1'b0);
      check("table_data", data_o, table_v[v].exp_data);
    end

    // Held enable: acks at cycles 10, 22, 34.
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = 32'h0;
    data_i   = '0;
    for (int c = 0; c <= 35; c++) begin
      @(posedge clk_i); #1;
      exp_ack = (c >= LAT) && (((c - LAT) % (LAT + 2)) == 0);
      if (exp_ack) model_data = model_mem[0];
      check("held_ack", {255'd0, ack_o}, {255'd0, exp_ack});
      check("held_data", data_o, model_data);
      if (c == 34) enable_i = 1'b0;
    end

    // Reset on the commit edge of a write to line 5.
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_00A0;
    data_i   = 256'hFF;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (LAT - 1) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    model_data = '0;
    check("rst_mid_ack", {255'd0, ack_o}, 256'd0);
    check("rst_mid_data", data_o, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_after_ack", {255'd0, ack_o}, 256'd0);
    do_txn(1'b0, 32'h0000_00A0, '0, 1'b0);
    check("rst_line5", data_o, pre5);

    // Inputs changed after acceptance must not redirect the request.
    do_txn(1'b0, 32'h0000_0040, '0, 1'b1);
    check("capture_line2", data_o, preload_val(2));
    do_txn(1'b0, 32'h0000_00E0, '0, 1'b0);
    check("capture_line7", data_o, preload_val(7));

    for (int n = 0; n < 150; n++) begin
      do_txn(1'($urandom), $urandom, {8{$urandom}}, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
